// File: rtl/terminal_pkg.sv
// Shared constants, field layout and state encoding for the terminal write-side controller.
package terminal_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 40;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 7;
    localparam int CHAR_W = 8;
    localparam int ATTR_W = 25;
    localparam int CELL_W = ATTR_W + CHAR_W;

    // Attribute layout {underline, fg, bg}; a cell is {attribute, char}.
    localparam int ATTR_BG_LSB = 0;
    localparam int ATTR_FG_LSB = 12;
    localparam int ATTR_UL_BIT = 24;
    localparam int CELL_CHAR_LSB = 0;
    localparam int CELL_ATTR_LSB = CHAR_W;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    localparam logic [ATTR_W-1:0] DEFAULT_ATTR = {1'b0, 12'hFFF, 12'h000};
    localparam logic [CHAR_W-1:0] BLANK_CHAR   = 8'h20;

    localparam logic [CHAR_W-1:0] CODE_BS = 8'h08;
    localparam logic [CHAR_W-1:0] CODE_LF = 8'h0A;
    localparam logic [CHAR_W-1:0] CODE_FF = 8'h0C;
    localparam logic [CHAR_W-1:0] CODE_CR = 8'h0D;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_SCROLL_COPY  = 2'd1;
    localparam logic [1:0] ST_SCROLL_CLEAR = 2'd2;
    localparam logic [1:0] ST_CLEAR        = 2'd3;

    function automatic logic [CELL_W-1:0] make_cell(input logic [ATTR_W-1:0] attr,
                                                    input logic [CHAR_W-1:0] ch);
        return {attr, ch};
    endfunction

endpackage

// File: rtl/term_scroll_engine.sv
// Scroll copy engine: walks rows 1..39 through the shared read port during vblank and
// writes each cell one row up on the following cycle.
module term_scroll_engine
    import terminal_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              vblank_i,
    input  logic [ROW_W-1:0]  vid_row_i,
    input  logic [COL_W-1:0]  vid_col_i,
    input  logic [CELL_W-1:0] buf_rd_i,
    output logic [ROW_W-1:0]  rd_row_o,
    output logic [COL_W-1:0]  rd_col_o,
    output logic              wr_en_o,
    output logic [ROW_W-1:0]  wr_row_o,
    output logic [COL_W-1:0]  wr_col_o,
    output logic [CELL_W-1:0] wr_data_o,
    output logic              done_o
);

    logic             active_q, active_d;
    logic [ROW_W-1:0] sr_q, sr_d;
    logic [COL_W-1:0] sc_q, sc_d;
    logic             wv_q, wv_d;
    logic [ROW_W-1:0] wr_q, wr_d;
    logic [COL_W-1:0] wc_q, wc_d;
    logic             last_q, last_d;
    logic             grant;

    assign grant = active_q && vblank_i;

    always_comb begin
        active_d = active_q;
        sr_d     = sr_q;
        sc_d     = sc_q;
        wv_d     = grant;
        wr_d     = wr_q;
        wc_d     = wc_q;
        last_d   = 1'b0;
        if (start_i) begin
            active_d = 1'b1;
            sr_d     = 6'd1;
            sc_d     = 7'd0;
        end else if (grant) begin
            wr_d   = sr_q - 6'd1;
            wc_d   = sc_q;
            last_d = (sr_q == LAST_ROW) && (sc_q == LAST_COL);
            if (sc_q == LAST_COL) begin
                sc_d = 7'd0;
                if (sr_q == LAST_ROW) begin
                    active_d = 1'b0;
                    sr_d     = 6'd0;
                end else begin
                    sr_d = sr_q + 6'd1;
                end
            end else begin
                sc_d = sc_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            sr_q     <= '0;
            sc_q     <= '0;
            wv_q     <= 1'b0;
            wr_q     <= '0;
            wc_q     <= '0;
            last_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            sr_q     <= sr_d;
            sc_q     <= sc_d;
            wv_q     <= wv_d;
            wr_q     <= wr_d;
            wc_q     <= wc_d;
            last_q   <= last_d;
        end
    end

    // The renderer owns the read port whenever the engine is not granted.
    assign rd_row_o  = grant ? sr_q : vid_row_i;
    assign rd_col_o  = grant ? sc_q : vid_col_i;
    assign wr_en_o   = wv_q;
    assign wr_row_o  = wr_q;
    assign wr_col_o  = wc_q;
    assign wr_data_o = buf_rd_i;
    assign done_o    = wv_q && last_q;

endmodule

// File: rtl/terminal_ctrl.sv
// Write-side controller for the 80x40 display buffer: cursor, control codes, clear and scroll.
//   state           | meaning
//   ST_IDLE         | accepting bytes; printable writes and cursor moves
//   ST_SCROLL_COPY  | engine copying rows 1..39 up by one during vblank
//   ST_SCROLL_CLEAR | blanking row 39 after a scroll
//   ST_CLEAR        | blanking the whole screen, then cursor home
module terminal_ctrl
    import terminal_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              attr_we,
    input  logic [ATTR_W-1:0] attr_in,
    input  logic              vblank,
    input  logic [ROW_W-1:0]  vid_row,
    input  logic [COL_W-1:0]  vid_col,
    output logic              buf_we,
    output logic [ROW_W-1:0]  buf_wr,
    output logic [COL_W-1:0]  buf_wc,
    output logic [CELL_W-1:0] buf_wd,
    output logic [ROW_W-1:0]  buf_rr,
    output logic [COL_W-1:0]  buf_rc,
    input  logic [CELL_W-1:0] buf_rd,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic [COL_W-1:0]  cur_col_q, cur_col_d;
    logic [ATTR_W-1:0] attr_q, attr_d;
    logic              we_q, we_d;
    logic [ROW_W-1:0]  wr_q, wr_d;
    logic [COL_W-1:0]  wc_q, wc_d;
    logic [CELL_W-1:0] wd_q, wd_d;
    logic              blank_q, blank_d;
    logic [ROW_W-1:0]  clr_row_q, clr_row_d;
    logic [COL_W-1:0]  clr_col_q, clr_col_d;
    logic              accept;
    logic              do_lf;
    logic              scroll_start;

    logic              eng_we;
    logic [ROW_W-1:0]  eng_wr;
    logic [COL_W-1:0]  eng_wc;
    logic [CELL_W-1:0] eng_wd;
    logic              eng_done;

    assign accept = rx_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        attr_d       = attr_we ? attr_in : attr_q;
        we_d         = 1'b0;
        wr_d         = wr_q;
        wc_d         = wc_q;
        wd_d         = wd_q;
        blank_d      = blank_q;
        clr_row_d    = clr_row_q;
        clr_col_d    = clr_col_q;
        do_lf        = 1'b0;
        scroll_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (rx_data >= BLANK_CHAR) begin
                        we_d    = 1'b1;
                        wr_d    = cur_row_q;
                        wc_d    = cur_col_q;
                        wd_d    = make_cell(attr_q, rx_data);
                        blank_d = 1'b0;
                        if (cur_col_q == LAST_COL) begin
                            cur_col_d = 7'd0;
                            do_lf     = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + 7'd1;
                        end
                    end else begin
                        case (rx_data)
                            CODE_CR: cur_col_d = 7'd0;
                            CODE_BS: if (cur_col_q != 7'd0) cur_col_d = cur_col_q - 7'd1;
                            CODE_LF: do_lf = 1'b1;
                            CODE_FF: begin
                                state_d   = ST_CLEAR;
                                clr_row_d = 6'd0;
                                clr_col_d = 7'd0;
                            end
                            default: ;
                        endcase
                    end
                    if (do_lf) begin
                        if (cur_row_q == LAST_ROW) begin
                            state_d      = ST_SCROLL_COPY;
                            scroll_start = 1'b1;
                        end else begin
                            cur_row_d = cur_row_q + 6'd1;
                        end
                    end
                end
            end
            ST_SCROLL_COPY: begin
                if (eng_done) begin
                    state_d   = ST_SCROLL_CLEAR;
                    clr_row_d = LAST_ROW;
                    clr_col_d = 7'd0;
                end
            end
            ST_SCROLL_CLEAR, ST_CLEAR: begin
                we_d    = 1'b1;
                wr_d    = clr_row_q;
                wc_d    = clr_col_q;
                blank_d = 1'b1;
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = 7'd0;
                    if (clr_row_q == LAST_ROW) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_CLEAR) begin
                            cur_row_d = 6'd0;
                            cur_col_d = 7'd0;
                        end
                    end else begin
                        clr_row_d = clr_row_q + 6'd1;
                    end
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_row_q <= '0;
            cur_col_q <= '0;
            attr_q    <= DEFAULT_ATTR;
            we_q      <= 1'b0;
            wr_q      <= '0;
            wc_q      <= '0;
            wd_q      <= '0;
            blank_q   <= 1'b0;
            clr_row_q <= '0;
            clr_col_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            attr_q    <= attr_d;
            we_q      <= we_d;
            wr_q      <= wr_d;
            wc_q      <= wc_d;
            wd_q      <= wd_d;
            blank_q   <= blank_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
        end
    end

    term_scroll_engine u_scroll (
        .clk       (clk),
        .reset     (reset),
        .start_i   (scroll_start),
        .vblank_i  (vblank),
        .vid_row_i (vid_row),
        .vid_col_i (vid_col),
        .buf_rd_i  (buf_rd),
        .rd_row_o  (buf_rr),
        .rd_col_o  (buf_rc),
        .wr_en_o   (eng_we),
        .wr_row_o  (eng_wr),
        .wr_col_o  (eng_wc),
        .wr_data_o (eng_wd),
        .done_o    (eng_done)
    );

    // Blank cells take the live attribute so an update lands on clears already in flight.
    assign buf_we   = we_q || eng_we;
    assign buf_wr   = eng_we ? eng_wr : wr_q;
    assign buf_wc   = eng_we ? eng_wc : wc_q;
    assign buf_wd   = eng_we ? eng_wd : (blank_q ? make_cell(attr_q, BLANK_CHAR) : wd_q);
    assign rx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign cur_row  = cur_row_q;
    assign cur_col  = cur_col_q;

endmodule

// File: tb/tb_terminal_ctrl.sv
// Randomized scoreboard bench for terminal_ctrl with a screen-level reference model.
module tb_terminal_ctrl;
    import terminal_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_data = 8'h00;
    logic        attr_we = 1'b0;
    logic [24:0] attr_in = '0;
    logic        vblank = 1'b1;
    logic [5:0]  vid_row = '0;
    logic [6:0]  vid_col = '0;
    logic        buf_we;
    logic [5:0]  buf_wr, buf_rr, cur_row;
    logic [6:0]  buf_wc, buf_rc, cur_col;
    logic [32:0] buf_wd, buf_rd;
    logic        busy;

    terminal_ctrl dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .attr_we(attr_we), .attr_in(attr_in), .vblank(vblank), .vid_row(vid_row), .vid_col(vid_col),
        .buf_we(buf_we), .buf_wr(buf_wr), .buf_wc(buf_wc), .buf_wd(buf_wd),
        .buf_rr(buf_rr), .buf_rc(buf_rc), .buf_rd(buf_rd),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always #5 clk = ~clk;

    // Display buffer with one-cycle synchronous read.
    logic [32:0] mem [0:39][0:79];
    logic        preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int r = 0; r < 40; r++)
                for (int c = 0; c < 80; c++)
                    mem[r][c] <= 33'(r * 80 + c);
        end else if (buf_we) begin
            mem[buf_wr][buf_wc] <= buf_wd;
        end
        buf_rd <= mem[buf_rr][buf_rc];
    end

    int total = 0;
    int bad = 0;
    logic [45:0] exp_q[$];
    logic [45:0] mon_e;
    logic        sb_on = 1'b0;
    int          vb_mode = 0;
    int          vb_cnt = 0;
    int          busy_cycles = 0;

    logic [32:0] scr [0:39][0:79];
    int          mr = 0, mc = 0;
    logic [24:0] mattr = 25'h0FFF000;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        vid_row = 6'($urandom_range(0, 39));
        vid_col = 7'($urandom_range(0, 79));
        vb_cnt++;
        case (vb_mode)
            0: vblank = 1'b1;
            1: vblank = ((vb_cnt % 500) < 100);
            default: vblank = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!reset && sb_on) begin
            if (buf_we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: row %0d col %0d data %0h, none expected", buf_wr, buf_wc, buf_wd);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", {buf_wr, buf_wc}, mon_e[45:33]);
                    check("write_data", buf_wd, mon_e[32:0]);
                end
            end
            if (!vblank || !busy) begin
                check("read_mux", {buf_rr, buf_rc}, {vid_row, vid_col});
            end
        end
    end

    task automatic push_w(input int r, input int c, input logic [32:0] d);
        exp_q.push_back({6'(r), 7'(c), d});
        scr[r][c] = d;
    endtask

    task automatic model_lf();
        if (mr < 39) begin
            mr++;
        end else begin
            for (int r = 0; r < 39; r++)
                for (int c = 0; c < 80; c++)
                    push_w(r, c, scr[r + 1][c]);
            for (int c = 0; c < 80; c++)
                push_w(39, c, {mattr, 8'h20});
        end
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (!rx_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        busy_cycles = n;
        if (!rx_ready) begin
            bad++;
            $display("FAIL ready_timeout: rx_ready still %0b after %0d cycles", rx_ready, n);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "bench stopped on timeout");
        end
    endtask

    task automatic check_cursor();
        check("cur_row", cur_row, mr);
        check("cur_col", cur_col, mc);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        wait_ready(40000);
        check_cursor();
        rx_valid = 1'b1;
        rx_data  = b;
        if (b >= 8'h20) begin
            push_w(mr, mc, {mattr, b});
            if (mc < 79) mc++;
            else begin
                mc = 0;
                model_lf();
            end
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08) begin
            if (mc > 0) mc--;
        end else if (b == 8'h0A) begin
            model_lf();
        end else if (b == 8'h0C) begin
            for (int r = 0; r < 40; r++)
                for (int c = 0; c < 80; c++)
                    push_w(r, c, {mattr, 8'h20});
            mr = 0;
            mc = 0;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic set_attr(input logic [24:0] a);
        @(negedge clk);
        wait_ready(40000);
        attr_we = 1'b1;
        attr_in = a;
        @(posedge clk);
        #1;
        attr_we = 1'b0;
        mattr   = a;
    endtask

    task automatic settle_and_compare_ram();
        @(negedge clk);
        wait_ready(40000);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        for (int r = 0; r < 40; r++)
            for (int c = 0; c < 80; c++)
                check("ram_cell", mem[r][c], scr[r][c]);
    endtask

    task automatic printable();
        send(8'($urandom_range(32, 255)));
    endtask

    initial begin
        logic [7:0] ctl [5];
        int k;
        ctl[0] = 8'h00; ctl[1] = 8'h01; ctl[2] = 8'h07; ctl[3] = 8'h09; ctl[4] = 8'h1B;
        for (int r = 0; r < 40; r++)
            for (int c = 0; c < 80; c++)
                scr[r][c] = 33'(r * 80 + c);

        // reset and preload
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_cur_row", cur_row, 0);
        check("reset_cur_col", cur_col, 0);
        check("reset_rx_ready", rx_ready, 1);
        check("reset_buf_we", buf_we, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_mux", {buf_rr, buf_rc}, {vid_row, vid_col});
        sb_on = 1'b1;

        // first char, then line wrap at column 79 and BS at column 0
        send(8'h41);
        @(negedge clk);
        check("first_char_col", cur_col, 1);
        send(8'h0D);
        repeat (5) send(8'h0A);
        repeat (79) printable();
        send(8'h42);
        send(8'h08);
        @(negedge clk);
        check_cursor();

        // scroll with vblank held high
        repeat (33) send(8'h0A);
        repeat (3) printable();
        vb_mode = 0;
        send(8'h0A);
        @(negedge clk);
        wait_ready(40000);
        check("scroll_busy_min", busy_cycles >= 3200, 1);
        check_cursor();
        settle_and_compare_ram();

        // scroll with vblank 100 high / 400 low
        vb_mode = 1;
        send(8'h0A);
        @(negedge clk);
        wait_ready(40000);
        check("scroll_slow_busy", busy_cycles >= 3200, 1);
        check_cursor();
        settle_and_compare_ram();

        // full clear with a non-default attribute
        set_attr(25'($urandom));
        send(8'h0C);
        @(negedge clk);
        wait_ready(40000);
        check("clear_busy_min", busy_cycles >= 3200, 1);
        check_cursor();
        settle_and_compare_ram();

        // random traffic
        vb_mode = 2;
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 99);
            if (k < 70) printable();
            else if (k < 76) send(8'h0D);
            else if (k < 82) send(8'h08);
            else if (k < 88) send(8'h0A);
            else if (k < 92) send(ctl[$urandom_range(0, 4)]);
            else if (k < 99) set_attr(25'($urandom));
            else send(8'h0C);
        end
        settle_and_compare_ram();

        // wrap at (39,79) triggers a scroll
        while (mr < 39) send(8'h0A);
        send(8'h0D);
        repeat (79) printable();
        printable();
        settle_and_compare_ram();
        check_cursor();

        // reset in the middle of a scroll
        send(8'h0A);
        repeat (300) @(negedge clk);
        sb_on = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_rx_ready", rx_ready, 1);
        check("midreset_buf_we", buf_we, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cur", {cur_row, cur_col}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        sb_on = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_rd_mux", {buf_rr, buf_rc}, {vid_row, vid_col});
        check("post_reset_ready", rx_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/terminal_ctrl.md
Name: terminal_ctrl

Overview:
- Write-side controller for the terminal's 80x40 display buffer.
- Consumes a byte stream of character codes and places characters at a hardware cursor using the current attribute.
- Handles control codes CR, LF, BS and FF.
- Scrolls the screen by copying rows through the buffer's single read port. Scroll reads are scheduled only during vertical blanking, so the VGA renderer keeps the read port during active video.

Parameters:
- COLS, 80, characters per row
- ROWS, 40, rows on screen

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  character byte offered
- rx_ready  out  1  controller accepts a byte when high
- rx_data  in  8  character or control code
- attr_we  in  1  load attribute register
- attr_in  in  25  {underline, fg[11:0], bg[11:0]}
- vblank  in  1  renderer is in vertical blank; read port may be taken
- vid_row  in  6  renderer read row
- vid_col  in  7  renderer read column
- buf_we  out  1  display buffer write strobe
- buf_wr  out  6  write row
- buf_wc  out  7  write column
- buf_wd  out  33  write data {ul, fg[11:0], bg[11:0], char[7:0]}
- buf_rr  out  6  read row (muxed)
- buf_rc  out  7  read column (muxed)
- buf_rd  in  33  read data; 1-cycle synchronous latency
- cur_row  out  6  cursor row
- cur_col  out  7  cursor column
- busy  out  1  scroll or clear in progress

Behaviour:
- Reset values:
  - State IDLE.
  - cur_row = 0, cur_col = 0.
  - Attribute = {0, 12'hFFF, 12'h000}.
  - buf_we = 0, busy = 0, rx_ready = 1.
  - Scroll counters = 0.
- Reset mid-operation aborts immediately. Partially scrolled or cleared memory is left as is.
- rx_ready = (state == IDLE). A byte is accepted when rx_valid && rx_ready.
- attr_we is honoured in any state. A new attribute applies to subsequent writes, including clear cells already in flight.
- Accepted byte in cycle t; effects register at t+1:
  - Printable (>= 0x20, plus 0x80-0xFF): buf_we=1, buf_wr=cur_row, buf_wc=cur_col, buf_wd={attr, rx_data}.
    - If cur_col < 79: cur_col+1.
    - Else: cur_col=0 and a line feed is applied.
  - 0x0D CR: cur_col=0.
  - 0x08 BS: if cur_col > 0 then cur_col-1; else no change. No write.
  - 0x0A LF:
    - If cur_row < 39: cur_row+1.
    - Else: cur_row stays 39 and the state goes to SCROLL_COPY.
  - 0x0C FF: state goes to CLEAR.
  - Other codes < 0x20: ignored, no write.
- SCROLL_COPY (busy=1):
  - grant = (state == SCROLL_COPY) && vblank, combinational.
  - buf_rr/buf_rc = grant ? (sr, sc) : (vid_row, vid_col), combinational.
  - sr starts at 1, sc at 0. Each granted cycle issues one read and advances sc. At sc == 79, sc wraps to 0 and sr increments.
  - A read issued in cycle t is always written in cycle t+1, even if vblank has fallen: buf_we=1, buf_wr=sr-1, buf_wc=sc (both registered), buf_wd = buf_rd passed through combinationally.
  - When vblank is low, no read is issued and counters hold. The engine resumes on the next vblank.
  - The copy phase takes exactly 3120 granted reads. After the final read at (39,79) and its write, the state goes to SCROLL_CLEAR.
- SCROLL_CLEAR (busy=1): one write per cycle to row 39, cols 0..79, data {attr, 8'h20}. Needs no vblank. Then IDLE.
- CLEAR (busy=1): one write per cycle over rows 0..39 x cols 0..79, row-major, data {attr, 8'h20}; 3200 cycles. Then cursor (0,0) and IDLE.
- The write port is owned exclusively by this block. The read port is shared only through the grant mux.
- Address arithmetic uses the COLS/ROWS limits only. No out-of-range address is ever emitted.

Decomposition:
- terminal_pkg contains:
  - COLS, ROWS
  - Attribute/cell field offsets
  - DEFAULT_ATTR, BLANK_CHAR (0x20)
  - Control code constants
  - State enum {IDLE, SCROLL_COPY, SCROLL_CLEAR, CLEAR}
- One sub-module: term_scroll_engine. It holds the sr/sc counters, the grant/read mux and the one-stage read-to-write pipeline. Its inputs are start, vblank and buf_rd; its outputs are the write triplet and done.

Test Plan:
- Assert reset, release -> cur=(0,0), rx_ready=1, buf_we=0, busy=0, buf_rr/rc track vid_row/vid_col.
- Send 0x41 after reset -> next cycle buf_we=1, wr=0, wc=0, wd=33'h0FFF00041; cur_col=1.
- Cursor at (5,79), send 0x42 -> write at (5,79); cursor (6,0). Then send BS at col 0 -> no change, no write.
- RAM model preloaded with cell = row*80+col. Cursor (39,3), send LF, vblank held 1 -> 3120 copies, then 80 blank writes. Row r (0..38) equals former row r+1; row 39 all {attr, 0x20}; cursor (39,3); rx_ready=0 until done.
- Same as previous with vblank 100 cycles high / 400 low -> no grant while vblank=0, buf_rr==vid_row then; final RAM identical to the previous scenario.
- Send FF -> 3200 writes of {attr, 0x20}, cursor (0,0). Separately, pulse reset mid-scroll -> IDLE, rx_ready=1, buf_we=0 immediately.
